// File: rtl/p1v_reset_ctrl.sv
// Reset sequencer for the p1v core: syncs/debounces resn_raw, enforces POR/min-pulse/release widths, holds reset on PLL loss.
// Optional watchdog is compiled in with P1V_RESET_WDT_EN; inp_resn is registered off the FSM state (high only in RUN).
module p1v_reset_ctrl #(
    parameter int unsigned POR_CYCLES      = 160000,
    parameter int unsigned DEBOUNCE_CYCLES = 1600,
    parameter int unsigned MIN_PULSE       = 16000,
    parameter int unsigned RELEASE_CYCLES  = 1600,
    parameter int unsigned WDT_CYCLES      = 16000000
) (
    input  logic       clock_160,
    input  logic       reset,
    input  logic       resn_raw,
    input  logic       pll_locked,
    input  logic       wdt_kick,
    output logic       inp_resn,
    output logic [1:0] rst_cause,
    output logic [7:0] reset_count,
    output logic       in_reset
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_POR     = 2'd0,
        S_RUN     = 2'd1,
        S_ASSERT  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_resn_s1;
    logic             r_resn_s2;
    logic             r_pll_s1;
    logic             r_pll_s2;
    logic             r_req_n_filt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_inp_resn;
    logic [1:0]       r_rst_cause;
    logic [7:0]       r_reset_count;
    logic             w_wdt_expire;
    logic             w_cause_upd;
    logic [1:0]       w_cause_d;
    logic             w_count_inc;
    logic             w_inp_resn_d;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_resn_s1 <= 1'b1;
            r_resn_s2 <= 1'b1;
            r_pll_s1  <= 1'b1;
            r_pll_s2  <= 1'b1;
        end else begin
            r_resn_s1 <= resn_raw;
            r_resn_s2 <= r_resn_s1;
            r_pll_s1  <= pll_locked;
            r_pll_s2  <= r_pll_s1;
        end
    end

    // The filtered request only follows s2 after it has differed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_req_n_filt <= 1'b1;
            r_deb_cnt    <= '0;
        end else if (r_resn_s2 == r_req_n_filt) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_req_n_filt <= r_resn_s2;
            r_deb_cnt    <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

`ifdef P1V_RESET_WDT_EN
    logic             r_wdt_s1;
    logic             r_wdt_s2;
    logic             r_wdt_s3;
    logic [CNT_W-1:0] r_wdt_cnt;
    logic             w_kick;

    assign w_kick = r_wdt_s2 ^ r_wdt_s3;

    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_wdt_s1  <= 1'b1;
            r_wdt_s2  <= 1'b1;
            r_wdt_s3  <= 1'b1;
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_s1 <= wdt_kick;
            r_wdt_s2 <= r_wdt_s1;
            r_wdt_s3 <= r_wdt_s2;
            if ((r_state != S_RUN) || w_kick) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
            end
        end
    end

    assign w_wdt_expire = (r_state == S_RUN) && (r_wdt_cnt == WDT_LAST);
`else
    logic [CNT_W:0] w_unused_wdt;
    assign w_unused_wdt = {wdt_kick, WDT_LAST};
    assign w_wdt_expire = 1'b0;
`endif

    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_state <= S_POR;
        end else begin
            r_state <= w_next;
        end
    end

    // PLL loss outranks everything but reset; watchdog outranks the external request.
    always_comb begin
        w_next      = r_state;
        w_cause_upd = 1'b0;
        w_cause_d   = r_rst_cause;
        w_count_inc = 1'b0;
        if (!r_pll_s2) begin
            w_next      = S_POR;
            w_cause_upd = 1'b1;
            w_cause_d   = 2'b11;
        end else begin
            case (r_state)
                S_POR: begin
                    if (r_cnt == POR_LAST) begin
                        if (!r_req_n_filt) begin
                            w_next      = S_ASSERT;
                            w_cause_upd = 1'b1;
                            w_cause_d   = 2'b01;
                        end else begin
                            w_next = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_wdt_expire) begin
                        w_next      = S_ASSERT;
                        w_cause_upd = 1'b1;
                        w_cause_d   = 2'b10;
                        w_count_inc = 1'b1;
                    end else if (!r_req_n_filt) begin
                        w_next      = S_ASSERT;
                        w_cause_upd = 1'b1;
                        w_cause_d   = 2'b01;
                        w_count_inc = 1'b1;
                    end
                end
                S_ASSERT: begin
                    if ((r_cnt == MIN_LAST) && r_req_n_filt) begin
                        w_next = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!r_req_n_filt) begin
                        w_next      = S_ASSERT;
                        w_cause_upd = 1'b1;
                        w_cause_d   = 2'b01;
                        w_count_inc = 1'b1;
                    end else if (r_cnt == REL_LAST) begin
                        w_next = S_RUN;
                    end
                end
                default: w_next = S_POR;
            endcase
        end
    end

    always_comb begin
        w_inp_resn_d = (r_state == S_RUN);
        w_cnt_clr    = (w_next != r_state) || !r_pll_s2;
        w_cnt_inc    = (r_state != S_RUN) && !((r_state == S_ASSERT) && (r_cnt == MIN_LAST));
    end

    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_inp_resn    <= 1'b0;
            r_rst_cause   <= 2'b00;
            r_reset_count <= 8'd0;
        end else begin
            r_inp_resn <= w_inp_resn_d;
            if (w_cause_upd) begin
                r_rst_cause <= w_cause_d;
            end
            if (w_count_inc && (r_reset_count != 8'hFF)) begin
                r_reset_count <= r_reset_count + 8'd1;
            end
        end
    end

    assign inp_resn    = r_inp_resn;
    assign in_reset    = ~r_inp_resn;
    assign rst_cause   = r_rst_cause;
    assign reset_count = r_reset_count;

endmodule

// File: tb/tb_p1v_reset_ctrl.sv
// Bench for p1v_reset_ctrl with short sequencing parameters; watchdog section active with P1V_RESET_WDT_EN.
module tb_p1v_reset_ctrl;

    localparam int POR = 20;
    localparam int DEB = 4;
    localparam int MIN = 10;
    localparam int REL = 5;
    localparam int WDT = 30;
`ifdef P1V_RESET_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    localparam int BOOT = 0;
    localparam int LIVE = 1;
    localparam int HOLD = 2;
    localparam int TAIL = 3;

    logic       clock_160;
    logic       reset;
    logic       resn_raw;
    logic       pll_locked;
    logic       wdt_kick;
    logic       inp_resn;
    logic [1:0] rst_cause;
    logic [7:0] reset_count;
    logic       in_reset;

    p1v_reset_ctrl #(
        .POR_CYCLES     (POR),
        .DEBOUNCE_CYCLES(DEB),
        .MIN_PULSE      (MIN),
        .RELEASE_CYCLES (REL),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clock_160  (clock_160),
        .reset      (reset),
        .resn_raw   (resn_raw),
        .pll_locked (pll_locked),
        .wdt_kick   (wdt_kick),
        .inp_resn   (inp_resn),
        .rst_cause  (rst_cause),
        .reset_count(reset_count),
        .in_reset   (in_reset)
    );

    initial begin
        clock_160 = 1'b0;
        forever #5 clock_160 = ~clock_160;
    end

    int total;
    int bad;
    bit auto_kick;

    // Reference model: mode plus the edge index at which the mode started counting.
    int       m_cyc;
    bit       m_rs[2];
    bit       m_ps[2];
    bit       m_ws[3];
    bit       m_filt;
    int       m_diff;
    int       m_mode;
    int       m_since;
    int       m_wdt_ref;
    bit       m_inp;
    bit [1:0] m_cause;
    int       m_count;

    function automatic void enter(input int mode);
        m_mode  = mode;
        m_since = m_cyc + 1;
    endfunction

    function automatic void bump();
        if (m_count < 255) m_count = m_count + 1;
    endfunction

    function automatic void model_step();
        int el;
        int old_mode;
        bit kick_edge;
        if (reset) begin
            m_rs = '{1'b1, 1'b1};
            m_ps = '{1'b1, 1'b1};
            m_ws = '{1'b1, 1'b1, 1'b1};
            m_filt = 1'b1;
            m_diff = 0;
            enter(BOOT);
            m_wdt_ref = m_cyc + 1;
            m_inp = 1'b0;
            m_cause = 2'd0;
            m_count = 0;
        end else begin
            el = m_cyc - m_since;
            old_mode = m_mode;
            kick_edge = (m_ws[1] != m_ws[2]);
            if (!m_ps[1]) begin
                enter(BOOT);
                m_cause = 2'd3;
            end else begin
                case (m_mode)
                    BOOT: if (el == POR - 1) begin
                        if (!m_filt) begin enter(HOLD); m_cause = 2'd1; end
                        else enter(LIVE);
                    end
                    LIVE: if (WDT_ON && (m_cyc - m_wdt_ref == WDT - 1)) begin
                        enter(HOLD); m_cause = 2'd2; bump();
                    end else if (!m_filt) begin
                        enter(HOLD); m_cause = 2'd1; bump();
                    end
                    HOLD: if (el >= MIN - 1 && m_filt) enter(TAIL);
                    default: if (!m_filt) begin
                        enter(HOLD); m_cause = 2'd1; bump();
                    end else if (el == REL - 1) enter(LIVE);
                endcase
            end
            if (old_mode != LIVE || kick_edge) m_wdt_ref = m_cyc + 1;
            m_inp = (old_mode == LIVE);
            if (m_rs[1] == m_filt) m_diff = 0;
            else if (m_diff == DEB - 1) begin m_filt = m_rs[1]; m_diff = 0; end
            else m_diff = m_diff + 1;
            m_rs[1] = m_rs[0]; m_rs[0] = resn_raw;
            m_ps[1] = m_ps[0]; m_ps[0] = pll_locked;
            m_ws[2] = m_ws[1]; m_ws[1] = m_ws[0]; m_ws[0] = wdt_kick;
        end
        m_cyc = m_cyc + 1;
    endfunction

    task automatic tick();
        @(posedge clock_160);
        model_step();
        @(negedge clock_160);
        if (auto_kick) wdt_kick = ~wdt_kick;
    endtask

    function automatic logic [11:0] dut_vec();
        return {inp_resn, in_reset, rst_cause, reset_count};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {inp,in_reset,cause,count}=%03h want %03h", name, act, exp);
        end
    endtask

    task automatic model_cmp(input string name);
        check(name, dut_vec(), {m_inp, ~m_inp, m_cause, 8'(m_count)});
    endtask

    typedef struct {
        bit       rst;
        bit       raw;
        bit       pll;
        int       n;
        bit       inp;
        bit [1:0] cause;
        bit [7:0] cnt;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit raw, input bit pll, input int n,
                                input bit inp, input bit [1:0] cause, input bit [7:0] cnt);
        vec_t v;
        v.rst = rst; v.raw = raw; v.pll = pll; v.n = n;
        v.inp = inp; v.cause = cause; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[$];
    int   lows;
    int   len;

    initial begin
        total = 0; bad = 0; m_cyc = 0; auto_kick = 1'b1;
        reset = 1'b1; resn_raw = 1'b1; pll_locked = 1'b1; wdt_kick = 1'b0;

        // Each row holds its inputs for n cycles; outputs must equal the row's values on every one of them.
        tbl.push_back(mk(1, 1, 1, 3,  0, 2'd0, 8'd0));   // reset state
        tbl.push_back(mk(0, 1, 1, 20, 0, 2'd0, 8'd0));   // POR hold
        tbl.push_back(mk(0, 1, 1, 1,  1, 2'd0, 8'd0));   // RUN output
        tbl.push_back(mk(0, 0, 1, 3,  1, 2'd0, 8'd0));   // 3-cycle glitch
        tbl.push_back(mk(0, 1, 1, 10, 1, 2'd0, 8'd0));
        tbl.push_back(mk(0, 0, 1, 6,  1, 2'd0, 8'd0));   // 8-cycle request
        tbl.push_back(mk(0, 0, 1, 1,  1, 2'd1, 8'd1));
        tbl.push_back(mk(0, 0, 1, 1,  0, 2'd1, 8'd1));
        tbl.push_back(mk(0, 1, 1, 14, 0, 2'd1, 8'd1));   // MIN + RELEASE low time
        tbl.push_back(mk(0, 1, 1, 1,  1, 2'd1, 8'd1));
        tbl.push_back(mk(0, 0, 1, 6,  1, 2'd1, 8'd1));   // 50-cycle request
        tbl.push_back(mk(0, 0, 1, 1,  1, 2'd1, 8'd2));
        tbl.push_back(mk(0, 0, 1, 1,  0, 2'd1, 8'd2));
        tbl.push_back(mk(0, 0, 1, 42, 0, 2'd1, 8'd2));
        tbl.push_back(mk(0, 1, 1, 12, 0, 2'd1, 8'd2));   // REL+DEB+3 to rise
        tbl.push_back(mk(0, 1, 1, 1,  1, 2'd1, 8'd2));
        tbl.push_back(mk(0, 0, 1, 6,  1, 2'd1, 8'd2));   // request, then PLL drop in RELEASE
        tbl.push_back(mk(0, 0, 1, 1,  1, 2'd1, 8'd3));
        tbl.push_back(mk(0, 0, 1, 1,  0, 2'd1, 8'd3));
        tbl.push_back(mk(0, 1, 1, 10, 0, 2'd1, 8'd3));
        tbl.push_back(mk(0, 1, 0, 1,  0, 2'd1, 8'd3));
        tbl.push_back(mk(0, 1, 1, 1,  0, 2'd1, 8'd3));
        tbl.push_back(mk(0, 1, 1, 1,  0, 2'd3, 8'd3));
        tbl.push_back(mk(0, 1, 1, 20, 0, 2'd3, 8'd3));   // 21-cycle hold after relock
        tbl.push_back(mk(0, 1, 1, 1,  1, 2'd3, 8'd3));
        tbl.push_back(mk(0, 0, 1, 6,  1, 2'd3, 8'd3));   // reset in the middle of ASSERT
        tbl.push_back(mk(0, 0, 1, 1,  1, 2'd1, 8'd4));
        tbl.push_back(mk(0, 0, 1, 1,  0, 2'd1, 8'd4));
        tbl.push_back(mk(1, 1, 1, 1,  0, 2'd0, 8'd0));
        tbl.push_back(mk(0, 1, 1, 20, 0, 2'd0, 8'd0));
        tbl.push_back(mk(0, 1, 1, 1,  1, 2'd0, 8'd0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; resn_raw = tbl[i].raw; pll_locked = tbl[i].pll;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                check($sformatf("vec%0d.c%0d", i, c), dut_vec(),
                      {tbl[i].inp, ~tbl[i].inp, tbl[i].cause, tbl[i].cnt});
            end
        end

        // 300 external events: count saturates at 255
        for (int k = 0; k < 300; k++) begin
            resn_raw = 1'b0;
            for (int c = 0; c < 8; c++) begin tick(); model_cmp("sat_seq"); end
            resn_raw = 1'b1;
            for (int c = 0; c < 16; c++) begin tick(); model_cmp("sat_seq"); end
        end
        check("sat_count", dut_vec(), {1'b1, 1'b0, 2'b01, 8'hFF});

        // Random segments against the model
        auto_kick = 1'b0;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        for (int s = 0; s < 400; s++) begin
            resn_raw   = ($urandom_range(0, 2) != 0);
            pll_locked = ($urandom_range(0, 15) != 0);
            reset      = ($urandom_range(0, 60) == 0);
            wdt_kick   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin tick(); model_cmp("rand"); end
        end

`ifdef P1V_RESET_WDT_EN
        reset = 1'b1; resn_raw = 1'b1; pll_locked = 1'b1; wdt_kick = 1'b0;
        tick(); tick(); reset = 1'b0;
        for (int k = 0; k < 51; k++) begin
            tick();
            model_cmp("wdt_expire_seq");
            if (k == 48) check("wdt_before", dut_vec(), {1'b1, 1'b0, 2'b00, 8'd0});
            if (k == 49) check("wdt_fire",   dut_vec(), {1'b1, 1'b0, 2'b10, 8'd1});
            if (k == 50) check("wdt_low",    dut_vec(), {1'b0, 1'b1, 2'b10, 8'd1});
        end
        lows = 0;
        for (int k = 0; k < 1100; k++) begin
            if (k % 20 == 0) wdt_kick = ~wdt_kick;
            tick();
            model_cmp("wdt_kick_seq");
            if (k >= 100 && !inp_resn) lows++;
        end
        check("wdt_kept_alive", 12'(lows), 12'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p1v_reset_ctrl.md
Name: p1v_reset_ctrl

Overview:
Reset sequencer between the board-level reset request (USB-serial DTR on fpga_resn) and the p1v core's inp_resn input. Runs in the clock_160 domain. Synchronizes and debounces the raw request, enforces power-on and minimum reset pulse widths, and holds the core in reset while the PLL is unlocked. Reports the last reset cause and a reset event count for debug LEDs and pins.

Parameters:
POR_CYCLES, 160000, power-on hold time in clock_160 cycles (1 ms).
DEBOUNCE_CYCLES, 1600, required stability of the synchronized request before acceptance (10 us).
MIN_PULSE, 16000, minimum inp_resn low time for any reset event (100 us).
RELEASE_CYCLES, 1600, extra low time after the request deasserts.
WDT_CYCLES, 16000000, watchdog timeout (100 ms); used only with the optional feature.

Ports:
clock_160  in  1  system clock
reset  in  1  synchronous active-high reset
resn_raw  in  1  asynchronous reset request, active low
pll_locked  in  1  PLL lock, asynchronous
wdt_kick  in  1  asynchronous watchdog kick (any edge)
inp_resn  out  1  core reset, active low, registered
rst_cause  out  2  last cause: 00 POR, 01 external, 10 watchdog, 11 PLL loss
reset_count  out  8  external and watchdog reset events, saturating
in_reset  out  1  equals ~inp_resn

Behaviour:
- Reset values: state=POR, inp_resn=0, in_reset=1, rst_cause=00, reset_count=0, all counters 0, sync flops=1.
- resn_raw, pll_locked and wdt_kick each pass through 2-flop synchronizers.
- Debounce:
  - req_n_filt starts at 1.
  - deb_cnt clears whenever s2==req_n_filt.
  - While s2 differs, deb_cnt increments. At DEBOUNCE_CYCLES-1, req_n_filt<=s2 and deb_cnt<=0.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Latency from raw edge to filtered edge is 2+DEBOUNCE_CYCLES cycles.
- Shared 24-bit cnt, cleared on every state entry.
- POR: cnt counts to POR_CYCLES-1. Then go to ASSERT if req_n_filt==0 (no count increment), else RUN.
- RUN: inp_resn=1. If req_n_filt==0, go to ASSERT, cause=01, reset_count+1.
- ASSERT: cnt saturates at MIN_PULSE-1. Once cnt==MIN_PULSE-1 and req_n_filt==1, go to RELEASE.
- RELEASE: after RELEASE_CYCLES, go to RUN. If req_n_filt returns to 0 first, go to ASSERT, cause=01, count+1.
- PLL loss: synchronized pll_locked==0 in any state forces POR with cause=11, and holds POR with cnt=0 until locked.
- Priority: reset > PLL loss > watchdog > external request.
- inp_resn=1 only in RUN. It is registered, so it rises 1 cycle after RUN entry and falls 1 cycle after a RUN exit decision.
- reset_count saturates at 255. rst_cause updates on entry to ASSERT or POR only.
- reset asserted mid-sequence returns to POR with all counters cleared.

Optional Feature:
Macro P1V_RESET_WDT_EN.
- Defined:
  - A synchronized wdt_kick edge clears wdt_cnt.
  - wdt_cnt counts only in RUN and clears outside RUN.
  - At WDT_CYCLES-1 the FSM goes to ASSERT with cause=10 and reset_count+1.
  - The release then follows the normal MIN_PULSE and RELEASE_CYCLES path, since req_n_filt==1.
- Undefined:
  - wdt_kick is ignored and no watchdog logic is synthesized.
  - rst_cause never reports 10.

Test Plan:
- Params POR=20, DEB=4, MIN=10, REL=5. Release reset with resn_raw=1 and pll_locked=1 -> inp_resn=0 for 21 cycles, then 1; rst_cause=00, reset_count=0.
- In RUN, pulse resn_raw low for 3 cycles -> no change to inp_resn; reset_count stays 0.
- In RUN, hold resn_raw low for 8 cycles -> inp_resn falls 2+4+1 cycles after the edge and stays low for at least 10+5 cycles; rst_cause=01, reset_count=1.
- Hold resn_raw low for 50 cycles -> inp_resn stays low throughout, then rises RELEASE+DEB+3 cycles after resn_raw rises.
- Drop pll_locked for 1 cycle during RELEASE -> POR restarts; rst_cause=11; 21-cycle hold after relock; reset_count unchanged.
- With P1V_RESET_WDT_EN and WDT=30: no kicks -> reset at RUN+30 with rst_cause=10; kick every 20 cycles -> no reset for 1000 cycles. 300 forced resets -> reset_count=255.
